// File: rtl/stage4_semester.sv
`default_nettype none
// ============================================================================
// Module   : stage4_semester
// Purpose  : Multi-cycle semester evaluator fed by stage3 daily results.
//            Accumulates pass counts, streaks and bonus points over DAYS
//            handshaked day results, then registers a two-bit grade.
// Revision : 1.0 - initial release
// ============================================================================
module stage4_semester #(
  parameter int DAYS       = 16,
  parameter int PASS_MIN   = 10,
  parameter int STREAK_MIN = 5,
  localparam int CW        = $clog2(DAYS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          day_valid,
  output logic          day_ready,
  input  logic          pass1,
  input  logic          pass2,
  input  logic          pass3,
  input  logic [1:0]    bonus2,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] max_streak,
  output logic [CW-1:0] commute_fail,
  output logic [1:0]    grade,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    JUDGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Constants at the widths they are compared against.
  localparam logic [CW-1:0] c_days_cw      = CW'(DAYS);
  localparam logic [CW+1:0] c_days_w       = (CW+2)'(DAYS);
  localparam logic [CW+1:0] c_pass_min_w   = (CW+2)'(PASS_MIN);
  localparam logic [CW+1:0] c_pass_half_w  = (CW+2)'(PASS_MIN >> 1);
  localparam logic [CW+1:0] c_streak_min_w = (CW+2)'(STREAK_MIN);
  localparam logic [1:0]    c_grade_a      = 2'b11;
  localparam logic [1:0]    c_grade_b      = 2'b10;
  localparam logic [1:0]    c_grade_c      = 2'b01;
  localparam logic [1:0]    c_grade_f      = 2'b00;

  state_t        r_state;
  logic [CW-1:0] r_day_cnt;
  logic [CW-1:0] r_cur_streak;
  logic [CW+1:0] r_bonus_sum;
  logic [CW-1:0] r_pass_cnt;
  logic [CW-1:0] r_max_streak;
  logic [CW-1:0] r_commute_fail;
  logic [1:0]    r_grade;

  logic          w_accept;
  logic [CW-1:0] w_day_next;
  logic [CW-1:0] w_streak_next;
  logic [CW+1:0] w_eff_raw;
  logic [CW+1:0] w_eff;
  logic          w_streak_ok;
  logic          w_unused;

  // Handshake and next-value arithmetic; everything is additive so no
  // wrap is possible given counters are bounded by DAYS.
  always_comb begin
    w_accept      = (r_state == RUN) && day_valid;
    w_day_next    = r_day_cnt + CW'(1);
    w_streak_next = r_cur_streak + CW'(1);
    w_eff_raw     = {2'b00, r_pass_cnt} + (r_bonus_sum >> 2);
    w_eff         = (w_eff_raw > c_days_w) ? c_days_w : w_eff_raw;
    w_streak_ok   = ({2'b00, r_max_streak} >= c_streak_min_w);
    // pass2 is already folded into pass3 upstream; it only rides the handshake.
    w_unused      = pass2;
  end

  // Semester FSM with all accumulators and the registered grade.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_day_cnt      <= '0;
      r_cur_streak   <= '0;
      r_bonus_sum    <= '0;
      r_pass_cnt     <= '0;
      r_max_streak   <= '0;
      r_commute_fail <= '0;
      r_grade        <= c_grade_f;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // start wins over any day_valid presented in these states.
          if (start) begin
            r_state        <= RUN;
            r_day_cnt      <= '0;
            r_cur_streak   <= '0;
            r_bonus_sum    <= '0;
            r_pass_cnt     <= '0;
            r_max_streak   <= '0;
            r_commute_fail <= '0;
            r_grade        <= c_grade_f;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_day_cnt <= w_day_next;
            if (!pass1) begin
              r_commute_fail <= r_commute_fail + CW'(1);
            end
            if (pass3) begin
              r_pass_cnt   <= r_pass_cnt + CW'(1);
              r_cur_streak <= w_streak_next;
              r_bonus_sum  <= r_bonus_sum + {{CW{1'b0}}, bonus2};
              if (w_streak_next > r_max_streak) begin
                r_max_streak <= w_streak_next;
              end
            end else begin
              r_cur_streak <= '0;
            end
            if (w_day_next == c_days_cw) begin
              r_state <= JUDGE;
            end
          end
        end
        JUDGE: begin
          if (w_eff >= c_pass_min_w) begin
            r_grade <= w_streak_ok ? c_grade_a : c_grade_b;
          end else if (w_eff >= c_pass_half_w) begin
            r_grade <= c_grade_c;
          end else begin
            r_grade <= c_grade_f;
          end
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Moore outputs decoded from state; counters drive ports directly.
  always_comb begin
    day_ready    = (r_state == RUN);
    done         = (r_state == DONE);
    pass_cnt     = r_pass_cnt;
    max_streak   = r_max_streak;
    commute_fail = r_commute_fail;
    grade        = r_grade;
  end

endmodule
`default_nettype wire

// File: doc/stage4_semester.md
Name: stage4_semester

Overview:
- Sequential evaluator directly downstream of stage3. It consumes one "day" result per handshake (pass1, pass2, pass3, bonus2) and accumulates pass counts, streaks and bonus points over DAYS days.
- After the last day it issues a registered semester grade.
- It converts the combinational daily pipeline into a multi-cycle campaign with a start/done protocol.

Parameters:
- DAYS, 16, number of day results per semester (2..63).
- PASS_MIN, 10, effective passes required for grade B or better.
- STREAK_MIN, 5, longest pass3 streak required for grade A.
- CW, $clog2(DAYS+1), counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin/restart semester; sampled only in IDLE or DONE.
- day_valid  in  1  day result present.
- day_ready  out  1  block accepts a day this cycle.
- pass1  in  1  commute result from stage1.
- pass2  in  1  work result from stage2.
- pass3  in  1  final daily result from stage3.
- bonus2  in  2  bonus points from stage2.
- pass_cnt  out  CW  days with pass3=1.
- max_streak  out  CW  longest run of consecutive pass3=1 days.
- commute_fail  out  CW  days with pass1=0.
- grade  out  2  11=A, 10=B, 01=C, 00=F; valid while done=1.
- done  out  1  semester finished, results stable.

Behaviour:
- Reset (async, rst_n=0):
  - State forced to IDLE.
  - All counters, cur_streak, bonus_sum, grade and done are 0.
  - day_ready is 0.
  - Reset mid-semester discards all progress.
- FSM states: IDLE, RUN, JUDGE, DONE.
- IDLE:
  - day_ready=0.
  - start=1: clear pass_cnt, max_streak, commute_fail, cur_streak, day_cnt, bonus_sum, grade; go to RUN.
- RUN:
  - day_ready=1 (Moore, from state only).
  - A day is accepted on any edge with day_valid=1 && day_ready=1. Gaps in day_valid are allowed; nothing changes while day_valid=0.
  - start is ignored in RUN.
  - Per accepted day:
    - day_cnt+1.
    - pass1=0: commute_fail+1.
    - pass3=1: pass_cnt+1, cur_streak+1, bonus_sum += bonus2. max_streak updates to max(max_streak, cur_streak+1) on the same edge.
    - pass3=0: cur_streak=0, bonus2 ignored.
    - pass2 is recorded nowhere. It is consumed for the handshake only; the stage3 chain already folds pass2 into pass3.
  - When the accepted day makes day_cnt==DAYS, go to JUDGE on that same edge.
- JUDGE (exactly one cycle):
  - day_ready=0.
  - eff = pass_cnt + (bonus_sum >> 2), saturated to DAYS.
  - grade registered at the end of JUDGE:
    - A if eff>=PASS_MIN && max_streak>=STREAK_MIN.
    - else B if eff>=PASS_MIN.
    - else C if eff>=(PASS_MIN>>1).
    - else F.
  - Next state DONE.
- DONE:
  - done=1; day_ready=0; all outputs held.
  - start=1: behaves as in IDLE (clear, go to RUN, done drops next cycle).
  - day_valid is ignored.
- Latency: last day accepted at edge N → JUDGE during cycle N..N+1 → grade valid and done=1 from edge N+1.
- Width rules:
  - bonus_sum is CW+2 bits and never wraps (max 3*DAYS).
  - Counters are CW bits and cannot exceed DAYS.
  - No subtraction anywhere.
- Simultaneous events:
  - start and day_valid in DONE: start wins, the day is not accepted.
  - rst_n low overrides everything.
- Outputs pass_cnt, max_streak and commute_fail are live during RUN (updated each accepted day).
- grade is 0 until JUDGE completes.

Test Plan:
- Reset: hold rst_n=0 mid-cycle → all outputs 0, day_ready=0; release and check IDLE holds with start=0 for 10 cycles.
- Perfect semester: start, then 16 consecutive days with pass3=1, pass1=1, bonus2=0 → pass_cnt=16, max_streak=16, commute_fail=0, grade=11, done=1 exactly one cycle after the 16th accept.
- Bonus rescue: 9 days pass3=1 with bonus2=3, alternating with 7 days pass3=0 → bonus_sum=27, eff=9+6=15, max_streak=2 (two passes placed adjacent once) → grade=10.
- Failing: 4 pass days (bonus2=0), 12 fail days, 12 of them with pass1=0 → eff=4 <5 → grade=00, commute_fail=12.
- Handshake/gaps: random day_valid gaps, day_valid pulses during IDLE/JUDGE/DONE → none counted; start during RUN ignored; assert rst_n=0 after day 7 → all zero, IDLE.
- Restart: in DONE assert start with day_valid=1 → counters clear, no day counted that cycle, done=0 next cycle, new semester completes normally.
